mult: RTL and testbench
=======================

// Module: mult
// PURPOSE
//  - IEEE-754 single-precision (binary32) floating-point multiplier, one registered pipeline stage.
//  - Sits in the FPU datapath beside the adder and divider.
//  - Operands and result are raw 32-bit IEEE-754 patterns.
//  - Denormals are flushed to zero; default rounding is truncation (round toward zero).
// PARAMETERS
//  - none (format fixed: 1 sign, 8 exponent bits, bias 127, 23 fraction bits)
// PORTS
//  clk     input   1   system clock; all state updates on rising edge
//  rst     input   1   reset, synchronous, active-high
//  en      input   1   capture enable; result updates only when en=1
//  A       input   32  operand A, IEEE-754 binary32
//  B       input   32  operand B, IEEE-754 binary32
//  result  output  32  registered product A*B, IEEE-754 binary32
// BEHAVIOUR
//  - One clock, one synchronous active-high reset (rst). On rst=1 at a rising edge: result <= 32'h0000_0000.
//  - rst has priority over en.
//  - Latency is 1 cycle. At a rising edge with en=1, result <= f(A,B). With en=0, result holds.
//  - Throughput is one operation per cycle. No handshake.
//  - Sign: sA^sB for finite nonzero and infinite results.
//  - Class decode, in priority order:
//    - A or B is NaN (exp=FF, frac!=0) -> 7FC00000.
//    - Inf*zero (zero includes denormal) -> 7FC00000.
//    - A or B is Inf -> {sign, 8'hFF, 23'h0}.
//    - A or B has exp=00 (zero or denormal) -> +0 (32'h00000000), regardless of operand signs.
//  - Normal path:
//    - mA={1,fracA}, mB={1,fracB} (24b each); P=mA*mB (48b).
//    - If P[47]=1: mant=P[46:24], e=eA+eB-127+1. Else mant=P[45:23], e=eA+eB-127.
//    - Compute e in >=10-bit signed width, so no wrap-around.
//    - Rounding: discard lower bits (truncate) unless MULT_ROUND_NEAREST_EN is defined.
//    - e>=255 -> {sign, FF, 0} (infinity). e<=0 -> +0 (underflow flush, no denormal output).
//    - Else result={sign, e[7:0], mant}.
//  - Inputs are sampled only at the rising edge, so inputs changing mid-cycle have no effect.
// CONFIGURATION
//  - MULT_ROUND_NEAREST_EN defined:
//    - Round to nearest, ties to even, using guard and sticky of the discarded product bits.
//    - A mantissa carry-out renormalises (e+1), then the overflow check is applied.
//  - MULT_ROUND_NEAREST_EN undefined (default): truncation. Latency is 1 cycle either way.
// TESTING
//  - 40400000*40000000 -> 40C00000 (3*2=6). C0400000*C0400000 -> 41100000. 40A00000^2 -> 41C80000.
//  - 4234851F*427C851F -> 453210E9. 4049999A*C1663D71 -> C2355062. C1526666*C240A3D7 -> 441E5374.
//  - Truncation: 3ACA62C1*3ACA62C1 -> 361FFFFE (361FFFFF with MULT_ROUND_NEAREST_EN).
//  - Zeros/denormals: 40400000*0 -> 0; C1526666*0 -> 00000000 (+0); 00800000*00180000 -> 0.
//  - Specials: 7F800000*7F800000 -> 7F800000. 7F800000*0 -> 7FC00000. 7F000000*7F000000 -> 7F800000.
//  - Control:
//    - result updates exactly one edge after operands are applied with en=1.
//    - en=0 holds the previous result.
//    - rst=1 clears result to 0 at the next edge, even with en=1.

Source files
------------

// File: rtl/mult.sv
// IEEE-754 binary32 multiplier with one registered stage; denormals flush to zero.
// Default rounding truncates; define MULT_ROUND_NEAREST_EN for round-to-nearest-even.
module mult (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] result
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // Normalise the 48-bit significand product, round it, then apply the exponent range limits.
    function automatic logic [31:0] round_pack(input logic              sign,
                                               input logic signed [9:0] e_sum,
                                               input logic [47:0]       p);
        logic [22:0]       mant;
        logic signed [9:0] e;
`ifdef MULT_ROUND_NEAREST_EN
        logic              guard;
        logic              sticky;
        logic [23:0]       mant_rnd;
`endif
        if (p[47]) begin
            mant = p[46:24];
            e    = e_sum + 10'sd1;
        end else begin
            mant = p[45:23];
            e    = e_sum;
        end
`ifdef MULT_ROUND_NEAREST_EN
        guard    = p[47] ? p[23] : p[22];
        sticky   = p[47] ? (|p[22:0]) : (|p[21:0]);
        mant_rnd = {1'b0, mant} + {23'd0, guard & (sticky | mant[0])};
        mant     = mant_rnd[22:0];
        if (mant_rnd[23]) begin
            e = e + 10'sd1;
        end
`endif
        if (e >= 10'sd255) begin
            return {sign, 8'hFF, 23'd0};
        end else if (e <= 10'sd0) begin
            return 32'h0000_0000;
        end else begin
            return {sign, e[7:0], mant};
        end
    endfunction

    logic              sign_p0;
    logic              a_nan_p0, b_nan_p0;
    logic              a_inf_p0, b_inf_p0;
    logic              a_zero_p0, b_zero_p0;
    logic [23:0]       mant_a_p0, mant_b_p0;
    logic [47:0]       prod_p0;
    logic signed [9:0] e_sum_p0;
    logic [31:0]       next_p0;
    logic [31:0]       result_p1;

`ifndef MULT_ROUND_NEAREST_EN
    logic              unused_low_p0;
    assign unused_low_p0 = ^prod_p0[22:0];
`endif

    always_comb begin
        sign_p0   = A[31] ^ B[31];
        a_nan_p0  = (&A[30:23]) && (|A[22:0]);
        b_nan_p0  = (&B[30:23]) && (|B[22:0]);
        a_inf_p0  = (&A[30:23]) && !(|A[22:0]);
        b_inf_p0  = (&B[30:23]) && !(|B[22:0]);
        a_zero_p0 = !(|A[30:23]);
        b_zero_p0 = !(|B[30:23]);
        mant_a_p0 = {1'b1, A[22:0]};
        mant_b_p0 = {1'b1, B[22:0]};
        prod_p0   = mant_a_p0 * mant_b_p0;
        // 10-bit signed exponent covers -125..383 without wrapping
        e_sum_p0  = $signed({2'b00, A[30:23]}) + $signed({2'b00, B[30:23]}) - 10'sd127;

        if (a_nan_p0 || b_nan_p0) begin
            next_p0 = QNAN;
        end else if ((a_inf_p0 && b_zero_p0) || (b_inf_p0 && a_zero_p0)) begin
            next_p0 = QNAN;
        end else if (a_inf_p0 || b_inf_p0) begin
            next_p0 = {sign_p0, 8'hFF, 23'd0};
        end else if (a_zero_p0 || b_zero_p0) begin
            next_p0 = 32'h0000_0000;
        end else begin
            next_p0 = round_pack(sign_p0, e_sum_p0, prod_p0);
        end
    end

    // p0 -> p1: result register
    always_ff @(posedge clk) begin
        if (rst) begin
            result_p1 <= 32'h0000_0000;
        end else if (en) begin
            result_p1 <= next_p0;
        end
    end

    assign result = result_p1;

endmodule

// File: tb/tb_mult.sv
// Self-checking bench for the binary32 multiplier: directed vectors plus randomized
// operands compared against an integer-arithmetic reference model.
module tb_mult;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] result;

    int total;
    int bad;
    logic [31:0] held;

    mult dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .A      (A),
        .B      (B),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact integer product, locate leading one, shift down, round, range-check.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        int                ea, eb, e, shift;
        longint unsigned   ma, mb, p, mant, rem, half;
        logic              s;
        logic [31:0]       mant_bits;
        bit a_nan, b_nan, a_inf, b_inf, a_z, b_z;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        a_nan = (ea == 255) && (a[22:0] != 0);
        b_nan = (eb == 255) && (b[22:0] != 0);
        a_inf = (ea == 255) && (a[22:0] == 0);
        b_inf = (eb == 255) && (b[22:0] == 0);
        a_z   = (ea == 0);
        b_z   = (eb == 0);
        if (a_nan || b_nan) return 32'h7FC0_0000;
        if ((a_inf && b_z) || (b_inf && a_z)) return 32'h7FC0_0000;
        if (a_inf || b_inf) return {s, 8'hFF, 23'd0};
        if (a_z || b_z) return 32'h0;
        ma = 64'(a[22:0]) + 64'h80_0000;
        mb = 64'(b[22:0]) + 64'h80_0000;
        p  = ma * mb;
        shift = (p >= 64'h8000_0000_0000) ? 24 : 23;
        mant  = p >> shift;
        rem   = p - (mant << shift);
        half  = 64'd1 << (shift - 1);
        e     = ea + eb - 127 + (shift - 23);
`ifdef MULT_ROUND_NEAREST_EN
        if (rem > half || (rem == half && mant[0])) mant = mant + 1;
        if (mant == (64'd1 << 24)) begin
            mant = mant >> 1;
            e = e + 1;
        end
`else
        if (rem > half) mant = mant + 0;
`endif
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return 32'h0;
        mant_bits = mant[31:0];
        return {s, e[7:0], mant_bits[22:0]};
    endfunction

    function automatic logic [31:0] rand_operand();
        int mode;
        logic [31:0] r;
        r = $urandom;
        mode = $urandom_range(0, 9);
        case (mode)
            0: ;
            1: r[30:23] = 8'h00;
            2: r[30:23] = 8'hFF;
            3: r[30:23] = 8'($urandom_range(200, 254));
            4: r[30:23] = 8'($urandom_range(1, 60));
            default: r[30:23] = 8'($urandom_range(90, 165));
        endcase
        return r;
    endfunction

    task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic e);
        @(negedge clk);
        A  = a;
        B  = b;
        en = e;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b1;
        A   = 32'h4040_0000;
        B   = 32'h4000_0000;
        @(posedge clk);
        #1;
        total++;
        if (result !== 32'h0) begin
            bad++;
            $display("FAIL reset_state: got %h expected 00000000", result);
        end
        @(negedge clk);
        rst = 1'b0;
        held = 32'h0;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
    } vec_t;

    task automatic test_vectors();
        vec_t v[15];
        v[0]  = '{32'h4040_0000, 32'h4000_0000, 32'h40C0_0000};
        v[1]  = '{32'hC040_0000, 32'hC040_0000, 32'h4110_0000};
        v[2]  = '{32'h40A0_0000, 32'h40A0_0000, 32'h41C8_0000};
        v[3]  = '{32'h4234_851F, 32'h427C_851F, 32'h4532_10E9};
        v[4]  = '{32'h4049_999A, 32'hC166_3D71, 32'hC235_5062};
        v[5]  = '{32'hC152_6666, 32'hC240_A3D7, 32'h441E_5374};
`ifdef MULT_ROUND_NEAREST_EN
        v[6]  = '{32'h3ACA_62C1, 32'h3ACA_62C1, 32'h361F_FFFF};
`else
        v[6]  = '{32'h3ACA_62C1, 32'h3ACA_62C1, 32'h361F_FFFE};
`endif
        v[7]  = '{32'h4040_0000, 32'h0000_0000, 32'h0000_0000};
        v[8]  = '{32'hC152_6666, 32'h0000_0000, 32'h0000_0000};
        v[9]  = '{32'h0080_0000, 32'h0018_0000, 32'h0000_0000};
        v[10] = '{32'h7F80_0000, 32'h7F80_0000, 32'h7F80_0000};
        v[11] = '{32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000};
        v[12] = '{32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000};
        v[13] = '{32'h7FC0_0001, 32'h7F80_0000, 32'h7FC0_0000};
        v[14] = '{32'h0080_0000, 32'h0080_0000, 32'h0000_0000};
        foreach (v[i]) begin
            apply(v[i].a, v[i].b, 1'b1);
            total++;
            if (result !== v[i].y) begin
                bad++;
                $display("FAIL vector_%0d: %h*%h got %h expected %h", i, v[i].a, v[i].b, result, v[i].y);
            end
            held = v[i].y;
        end
    endtask

    task automatic test_latency();
        logic [31:0] exp_new;
        exp_new = ref_mul(32'h40A0_0000, 32'h4040_0000);
        @(negedge clk);
        A  = 32'h40A0_0000;
        B  = 32'h4040_0000;
        en = 1'b1;
        #1;
        total++;
        if (result !== held) begin
            bad++;
            $display("FAIL latency_before_edge: got %h expected %h", result, held);
        end
        @(posedge clk);
        #1;
        total++;
        if (result !== exp_new) begin
            bad++;
            $display("FAIL latency_after_edge: got %h expected %h", result, exp_new);
        end
        held = exp_new;
        // operands change after the edge must not disturb the stored product
        A  = 32'h7F80_0000;
        B  = 32'h0000_0000;
        en = 1'b0;
        #3;
        total++;
        if (result !== held) begin
            bad++;
            $display("FAIL midcycle_change: got %h expected %h", result, held);
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 6; i++) begin
            apply(rand_operand(), rand_operand(), 1'b0);
            total++;
            if (result !== held) begin
                bad++;
                $display("FAIL hold_%0d: got %h expected %h", i, result, held);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        logic        e;
        for (int i = 0; i < 400; i++) begin
            a = rand_operand();
            b = rand_operand();
            e = ($urandom_range(0, 4) != 0);
            apply(a, b, e);
            if (e) held = ref_mul(a, b);
            total++;
            if (result !== held) begin
                bad++;
                $display("FAIL random_%0d: %h*%h en=%0b got %h expected %h", i, a, b, e, result, held);
            end
        end
    endtask

    task automatic test_reset_priority();
        apply(32'h4040_0000, 32'h4000_0000, 1'b1);
        held = 32'h40C0_0000;
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b1;
        A   = 32'h40A0_0000;
        B   = 32'h40A0_0000;
        @(posedge clk);
        #1;
        total++;
        if (result !== 32'h0) begin
            bad++;
            $display("FAIL reset_priority: got %h expected 00000000", result);
        end
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (result !== 32'h0) begin
            bad++;
            $display("FAIL reset_then_hold: got %h expected 00000000", result);
        end
        held = 32'h0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        held  = 32'h0;
        rst   = 1'b1;
        en    = 1'b0;
        A     = 32'h0;
        B     = 32'h0;
        test_reset();
        test_vectors();
        test_latency();
        test_hold();
        test_back_to_back();
        test_reset_priority();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
